// File: rtl/div_pkg.sv
// Shared definitions for the arithmetic lab datapath: FSM encoding, default
// operand width and the iteration-counter width helper.
package div_pkg;

  localparam int DEFAULT_SIZE = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // The counter must hold SIZE itself, not just SIZE-1.
  function automatic int cnt_width(input int size);
    return $clog2(size + 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift in the next dividend
// bit, trial-subtract the divisor, keep the difference when it does not underflow.
module div_step #(
  parameter int SIZE = 8
) (
  input  logic [SIZE:0]   partial,
  input  logic            dbit,
  input  logic [SIZE-1:0] divisor,
  output logic [SIZE:0]   partial_next,
  output logic            qbit
);

  logic [SIZE:0] p;
  logic [SIZE:0] diff;

  // The incoming partial is always below the divisor, so its MSB is zero and
  // shifting it out loses nothing.
  assign p    = (partial << 1) | {{SIZE{1'b0}}, dbit};
  assign diff = p - {1'b0, divisor};
  assign qbit = (p >= {1'b0, divisor});
  assign partial_next = qbit ? diff : p;

endmodule

// File: rtl/div_machine.sv
// Sequential unsigned restoring divider, one quotient bit per clock, with a
// start/done handshake. Divide-by-zero short-circuits straight to DONE.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start; results from the last operation held
// CALC    | one restoring iteration per cycle, count runs SIZE..1
// DONE    | single-cycle done pulse, results valid
module div_machine
  import div_pkg::*;
#(
  parameter int SIZE = DEFAULT_SIZE
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [SIZE-1:0] quotient,
  output logic [SIZE-1:0] remainder,
  output logic            div_by_zero
);

  localparam int CW = cnt_width(SIZE);

  state_t          state, state_next;
  logic [SIZE-1:0] dividend;
  logic [SIZE-1:0] divisor;
  logic [SIZE-1:0] qwork;
  logic [SIZE:0]   partial;
  logic [SIZE:0]   partial_nx;
  logic            qbit;
  logic [CW-1:0]   count;
  logic            last_step;

  div_step #(.SIZE(SIZE)) u_step (
    .partial      (partial),
    .dbit         (dividend[SIZE-1]),
    .divisor      (divisor),
    .partial_next (partial_nx),
    .qbit         (qbit)
  );

  assign last_step = (count == CW'(1));
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start) state_next = (b == '0) ? ST_DONE : ST_CALC;
      ST_CALC: if (last_step) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dividend    <= '0;
      divisor     <= '0;
      qwork       <= '0;
      partial     <= '0;
      count       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (b == '0) begin
              quotient    <= '1;
              remainder   <= a;
              div_by_zero <= 1'b1;
            end else begin
              dividend    <= a;
              divisor     <= b;
              qwork       <= '0;
              partial     <= '0;
              count       <= CW'(SIZE);
              div_by_zero <= 1'b0;
            end
          end
        end
        ST_CALC: begin
          dividend <= dividend << 1;
          partial  <= partial_nx;
          qwork    <= {qwork[SIZE-2:0], qbit};
          count    <= count - CW'(1);
          // Publish on the final iteration so the outputs are valid in DONE.
          if (last_step) begin
            quotient  <= {qwork[SIZE-2:0], qbit};
            remainder <= partial_nx[SIZE-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule
